// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - 3x3 raster window generator ahead of the Sobel kernels
// Define SOBEL_WIN_FRAME_CNT_EN to add the frame_cnt output.
module sobel_window_gen #(
  parameter int ROWS = 242,
  parameter int COLS = 247,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [7:0]    in_pixel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [71:0]   out_win,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          frame_done,
  output logic          sof_err
`ifdef SOBEL_WIN_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [7:0]    r_lb0 [COLS];
  logic [7:0]    r_lb1 [COLS];
  logic [71:0]   r_win;
  logic          r_out_valid;
  logic [71:0]   r_out_win;
  logic [RW-1:0] r_out_row;
  logic [CW-1:0] r_out_col;
  logic          r_frame_done;
  logic          r_sof_err;

  logic          w_acc;
  logic          w_sof;
  logic          w_proc;
  logic          w_sof_err;
  logic          w_emit;
  logic          w_last_col;
  logic          w_last_row;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic [71:0]   w_win_next;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_acc      = in_valid && in_ready;
  assign w_sof      = w_acc && in_sof;
  assign w_proc     = w_acc && (in_sof || (r_state == S_RUN));
  // An SOF pixel is always treated as (0,0), whatever the counters say.
  assign w_row      = w_sof ? '0 : r_row;
  assign w_col      = w_sof ? '0 : r_col;
  assign w_sof_err  = w_sof && (r_state == S_RUN) && ((r_row != '0) || (r_col != '0));
  assign w_emit     = w_proc && (w_row >= RW'(2)) && (w_col >= CW'(2));
  assign w_last_col = (w_col == CW'(COLS - 1));
  assign w_last_row = (w_row == RW'(ROWS - 1));

  always_comb begin
    w_win_next = r_win;
    for (int r = 0; r < 3; r++) begin
      w_win_next[(r*3)*8 +: 8]   = r_win[(r*3+1)*8 +: 8];
      w_win_next[(r*3+1)*8 +: 8] = r_win[(r*3+2)*8 +: 8];
    end
    w_win_next[2*8 +: 8] = r_lb1[w_col];
    w_win_next[5*8 +: 8] = r_lb0[w_col];
    w_win_next[8*8 +: 8] = in_pixel;
  end

  always_ff @(posedge clk) begin
    if (w_proc) begin
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb0[w_col] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_win        <= '0;
      r_out_valid  <= 1'b0;
      r_out_win    <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_sof_err    <= w_sof_err;
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_proc) begin
        r_win   <= w_win_next;
        r_state <= S_RUN;
        if (w_last_col) begin
          r_col <= '0;
          if (w_last_row) begin
            r_row        <= '0;
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
          end else begin
            r_row <= w_row + RW'(1);
          end
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
        // Accept only happens when the output slot is free or draining.
        if (w_emit) begin
          r_out_valid <= 1'b1;
          r_out_win   <= w_win_next;
          r_out_row   <= w_row - RW'(1);
          r_out_col   <= w_col - CW'(1);
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_win    = r_out_win;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign frame_done = r_frame_done;
  assign sof_err    = r_sof_err;

`ifdef SOBEL_WIN_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (r_frame_done) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - randomized self-checking bench for sobel_window_gen
// Reference keeps the received image in an array and cuts 3x3 windows from it.
module tb_sobel_window_gen;

  localparam int R  = 4;
  localparam int C  = 5;
  localparam int RW = $clog2(R);
  localparam int CW = $clog2(C);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic [7:0]    in_pixel;
  logic          out_valid;
  logic          out_ready;
  logic [71:0]   out_win;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          frame_done;
  logic          sof_err;
`ifdef SOBEL_WIN_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  sobel_window_gen #(.ROWS(R), .COLS(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_win    (out_win),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done),
    .sof_err    (sof_err)
`ifdef SOBEL_WIN_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          row;
    int          col;
    logic [71:0] win;
  } exp_t;

  typedef struct {
    logic       sof;
    logic [7:0] pix;
  } pix_t;

  exp_t        exp_q[$];
  pix_t        pix_q[$];
  logic [7:0]  img [R][C];
  bit          m_active;
  int          m_r, m_c;
  bit          pend_fd, pend_err;
  int          n_chk, n_pass;
  int          n_win, n_fd, n_err, n_fd_total;
  logic [71:0] first_win, last_win;
  int          last_row, last_col;

  localparam logic [71:0] W_FIRST = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] W_LAST  = {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7};

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_accept(input logic s, input logic [7:0] p);
    exp_t e;
    if (s) begin
      if (m_active && (m_r != 0 || m_c != 0)) pend_err = 1;
      m_active = 1;
      m_r = 0;
      m_c = 0;
    end
    if (!m_active) return;
    img[m_r][m_c] = p;
    if (m_r >= 2 && m_c >= 2) begin
      e.row = m_r - 1;
      e.col = m_c - 1;
      e.win = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.win[(r*3+c)*8 +: 8] = img[m_r-2+r][m_c-2+c];
      exp_q.push_back(e);
    end
    if (m_c == C - 1) begin
      m_c = 0;
      if (m_r == R - 1) begin
        m_r = 0;
        m_active = 0;
        pend_fd = 1;
      end else begin
        m_r++;
      end
    end else begin
      m_c++;
    end
  endtask

  task automatic cycle(input logic v, input logic s, input logic [7:0] p, input logic ordy,
                       output logic acc);
    in_valid  = v;
    in_sof    = s;
    in_pixel  = p;
    out_ready = ordy;
    @(negedge clk);
    chk("in_ready", in_ready, !out_valid || ordy);
    chk("frame_done", frame_done, pend_fd);
    chk("sof_err", sof_err, pend_err);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (out_valid && exp_q.size() != 0) begin
      chk("out_win", out_win, exp_q[0].win);
      chk("out_row", out_row, exp_q[0].row);
      chk("out_col", out_col, exp_q[0].col);
      if (ordy) begin
        n_win++;
        if (n_win == 1) first_win = out_win;
        last_win = out_win;
        last_row = int'(out_row);
        last_col = int'(out_col);
        void'(exp_q.pop_front());
      end
    end
    if (frame_done) begin
      n_fd++;
      n_fd_total++;
    end
    if (sof_err) n_err++;
    pend_fd  = 0;
    pend_err = 0;
    acc = v && in_ready;
    if (acc) model_accept(s, p);
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input bit seq);
    pix_t px;
    for (int i = 0; i < R * C; i++) begin
      px.sof = (i == 0);
      px.pix = seq ? 8'(i) : 8'($urandom_range(255));
      pix_q.push_back(px);
    end
  endtask

  task automatic clear_stats();
    n_win = 0;
    n_fd  = 0;
    n_err = 0;
  endtask

  task automatic drain(input int gap, input int stall, input bit hold10);
    int   budget;
    int   hold;
    bit   held;
    logic v, ordy, acc;
    budget = 3000;
    hold   = 0;
    held   = 0;
    while (pix_q.size() != 0 && budget > 0) begin
      if (hold10 && !held && out_valid) begin
        hold = 10;
        held = 1;
      end
      v = ($urandom_range(99) >= gap);
      if (hold > 0) begin
        ordy = 0;
        hold--;
      end else begin
        ordy = ($urandom_range(99) >= stall);
      end
      cycle(v, v ? pix_q[0].sof : 1'b0, v ? pix_q[0].pix : 8'd0, ordy, acc);
      if (acc) void'(pix_q.pop_front());
      budget--;
    end
    while (exp_q.size() != 0 && budget > 0) begin
      cycle(0, 0, 8'd0, 1, acc);
      budget--;
    end
    repeat (2) cycle(0, 0, 8'd0, 1, acc);
    chk("drain_budget", budget > 0, 1);
  endtask

  initial begin
    logic acc;
    pix_t px;
    n_chk = 0;
    n_pass = 0;
    n_fd_total = 0;
    m_active = 0;
    pend_fd = 0;
    pend_err = 0;
    clear_stats();
    rst_n = 0;
    in_valid = 0;
    in_sof = 0;
    in_pixel = 0;
    out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_win", out_win, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_in_ready", in_ready, 1);

    // Directed ramp frame, downstream always ready.
    clear_stats();
    push_frame(1);
    drain(0, 0, 0);
    chk("t1_nwin", n_win, 6);
    chk("t1_first", first_win, W_FIRST);
    chk("t1_last", last_win, W_LAST);
    chk("t1_last_row", last_row, 2);
    chk("t1_last_col", last_col, 3);
    chk("t1_nfd", n_fd, 1);

    // Same frame with a 10-cycle backpressure stall after the first window.
    clear_stats();
    push_frame(1);
    drain(0, 0, 1);
    chk("t2_nwin", n_win, 6);
    chk("t2_first", first_win, W_FIRST);
    chk("t2_nfd", n_fd, 1);

    // Three pixels without SOF are dropped.
    clear_stats();
    px.sof = 0;
    for (int i = 0; i < 3; i++) begin
      px.pix = 8'($urandom_range(255));
      pix_q.push_back(px);
    end
    push_frame(0);
    drain(30, 20, 0);
    chk("t3_nwin", n_win, 6);
    chk("t3_nerr", n_err, 0);

    // SOF reasserted at (2,3).
    clear_stats();
    for (int i = 0; i < 2 * C + 3; i++) begin
      px.sof = (i == 0);
      px.pix = 8'($urandom_range(255));
      pix_q.push_back(px);
    end
    push_frame(0);
    drain(20, 20, 0);
    chk("t4_nerr", n_err, 1);
    chk("t4_nwin", n_win, 7);
    chk("t4_nfd", n_fd, 1);

    // Random frames with input gaps and output stalls.
    clear_stats();
    for (int f = 0; f < 20; f++) push_frame(0);
    drain(50, 30, 0);
    chk("t5_nwin", n_win, 20 * 6);
    chk("t5_nfd", n_fd, 20);

    // Reset while a window is held on the output.
    push_frame(0);
    for (int i = 0; i < 20; i++) begin
      cycle(pix_q.size() != 0, pix_q.size() != 0 ? pix_q[0].sof : 1'b0,
            pix_q.size() != 0 ? pix_q[0].pix : 8'd0, 0, acc);
      if (acc) void'(pix_q.pop_front());
    end
    chk("t6_pre_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_win", out_win, 0);
    exp_q.delete();
    pix_q.delete();
    m_active = 0;
    pend_fd = 0;
    pend_err = 0;
    n_fd_total = 0;
    in_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;

    clear_stats();
    for (int f = 0; f < 3; f++) push_frame(0);
    drain(40, 40, 0);
    chk("t7_nwin", n_win, 18);
    chk("t7_nfd", n_fd, 3);
    chk("final_queue_empty", exp_q.size(), 0);
`ifdef SOBEL_WIN_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, n_fd_total);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Synthesizable streaming front end for the Sobel stage.
- Accepts an 8-bit grayscale pixel stream in raster order, buffers two image lines, and emits one 3x3 neighbourhood per interior pixel.
- Each window carries its centre coordinates; the downstream Sobel kernel forces border pixels to 0 from those coordinates.
- Sits between the image source (file reader or camera) and the Sobel horizontal/vertical kernels.

Parameters:
- ROWS, 242, image height in pixels (>=3).
- COLS, 247, image width in pixels (>=3).
- RW, $clog2(ROWS), row coordinate width.
- CW, $clog2(COLS), column coordinate width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pixel present.
- in_ready  out  1  block can accept the pixel.
- in_sof  in  1  marks the first pixel (0,0) of a frame; qualified by in_valid.
- in_pixel  in  8  pixel value.
- out_valid  out  1  window present.
- out_ready  in  1  downstream accepts the window.
- out_win  out  72  3x3 window; w[r][c] at bits [(r*3+c)*8 +: 8], r=0 top row, c=0 left column.
- out_row  out  RW  centre row of the window.
- out_col  out  CW  centre column of the window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- sof_err  out  1  one-cycle pulse when in_sof arrives mid-frame.

Behaviour:
- Reset (async, rst_n=0): state=S_IDLE; row/col counters=0; 3x3 registers=0; out_valid=0; out_win=0; out_row=0; out_col=0; frame_done=0; sof_err=0. Line-buffer RAM contents are not reset.
- Accept: handshake = in_valid & in_ready. in_ready = !out_valid | out_ready, in every state.
- S_IDLE: accepted pixels with in_sof=0 are discarded. A pixel with in_sof=1 is processed as (0,0); go to S_RUN.
- S_RUN, per accepted pixel at (row,col):
  - Shift the window left one column.
  - New right column is top=lb1[col], mid=lb0[col], bottom=in_pixel.
  - Then lb1[col]<=lb0[col] and lb0[col]<=in_pixel.
  - col increments; at COLS-1 it wraps to 0 and row increments.
- Emit: if row>=2 and col>=2 on accept, the next cycle sets out_valid=1, out_row=row-1, out_col=col-1, out_win=updated window. Latency is 1 cycle from accept.
- Window count: exactly (ROWS-2)*(COLS-2) windows per frame. A window is never formed across a line wrap, because col<2 suppresses emit.
- Hold: out_valid stays 1 and out_* stay stable until out_ready=1. Same-cycle accept+emit with out_ready=1 replaces the output register with no bubble.
- End of frame: accepting (ROWS-1,COLS-1) returns the FSM to S_IDLE and pulses frame_done the next cycle. The last window can still be pending on the output and is still delivered.
- in_sof=1 in S_RUN at a position other than (0,0): pulse sof_err; restart counters at (0,0) using this pixel; the pending output window is unaffected.
- Pixel arithmetic: pure data movement, no arithmetic on pixel values. Counters are unsigned and wrap only at ROWS-1/COLS-1.
- Reset mid-frame: everything returns to the reset state immediately. Any in-flight window is dropped.

Optional Feature:
- SOBEL_WIN_FRAME_CNT_EN defined: adds output port frame_cnt [15:0], reset to 0, incremented on each frame_done pulse, wrapping 65535->0.
- Undefined: no port and no counter logic.

Test Plan:
- ROWS=4, COLS=5, pixels 0..19 streamed, in_sof on the first, out_ready=1 -> 6 windows. First window (1,1) is {0,1,2,5,6,7,10,11,12}; last window (2,3) is {7,8,9,12,13,14,17,18,19}; frame_done pulses once.
- Same frame with out_ready held 0 for 10 cycles after the first window -> in_ready=0 while out_valid=1; window (1,1) holds stable; no windows lost or duplicated.
- Random in_valid gaps (50%) over a 242x247 frame compared against a software model -> 58800 windows, all matching.
- 3 pixels without in_sof, then a frame -> the first 3 are discarded; windows match a frame starting at the in_sof pixel.
- in_sof reasserted at pixel (2,3) -> sof_err pulse; the following frame outputs are correct.
- rst_n low while out_valid=1 -> out_valid=0 immediately (asynchronously); the next frame decodes correctly.
- With SOBEL_WIN_FRAME_CNT_EN defined, 3 frames -> frame_cnt=3.
